led_pattern_gen: RTL and testbench

Parametrised LED pattern engine for the board's LED bank, replacing the free-running counter blinky. A prescaler derives a pattern tick from the system clock. A four-mode sequencer (binary count, bouncing chase, PWM breathe, blink) drives N_LEDS registered outputs. An external, already-debounced single-cycle pulse cycles the mode.

---
 rtl/led_pattern_pkg.sv | 22 ++
 rtl/led_pattern_gen_tick_prescaler.sv | 33 +++
 rtl/led_pattern_gen.sv | 144 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern engine: the mode encoding and its
// wrap-around successor.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_t;

    // Mode order used by the mode_next button; BLINK wraps back to BINARY.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_BINARY:  next_mode = MODE_CHASE;
            MODE_CHASE:   next_mode = MODE_BREATHE;
            MODE_BREATHE: next_mode = MODE_BLINK;
            default:      next_mode = MODE_BINARY;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Free-running divide-by-DIV prescaler. tick is high for one clk every DIV
// clks, in the cycle where the count sits at DIV-1. clr restarts the count
// so the next tick lands DIV-1 cycles after the clearing edge.
module tick_prescaler #(
    parameter int DIV = 1_200_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] presc;

    // Count 0..DIV-1 and wrap; a clear request overrides the count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr || presc == LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// Four-mode LED pattern engine: binary count, bouncing chase, PWM breathe and
// blink. Pattern state advances on each prescaler tick; mode_next cycles the
// mode, clears the pattern state and restarts the prescaler. led is a
// registered function of the current mode and state.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS    = 5,
    parameter int TICK_DIV  = 1_200_000,
    parameter int PWM_BITS  = 8,
    parameter int DUTY_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_next,
    output logic [1:0]        mode,
    output logic              tick,
    output logic [N_LEDS-1:0] led
);

    localparam int                   POS_W    = $clog2(N_LEDS);
    localparam logic [POS_W-1:0]     POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [PWM_BITS-1:0]  DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0]  DUTY_INC = PWM_BITS'(DUTY_STEP);
    localparam logic [PWM_BITS-1:0]  DUTY_TOP = DUTY_MAX - DUTY_INC;
    localparam logic [N_LEDS-1:0]    LED_ONE  = N_LEDS'(1);

    mode_t               mode_q;
    logic [N_LEDS-1:0]   step;
    logic [POS_W-1:0]    pos;
    logic                chase_up;
    logic [PWM_BITS-1:0] duty;
    logic                breathe_up;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                phase;
    logic [N_LEDS-1:0]   led_next;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_next),
        .tick (tick)
    );

    // PWM counter free-runs; a mode change deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Mode and pattern sequencer; mode_next wins over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_BINARY;
            step       <= '0;
            pos        <= '0;
            chase_up   <= 1'b1;
            duty       <= '0;
            breathe_up <= 1'b1;
            phase      <= 1'b0;
        end else if (mode_next) begin
            mode_q     <= next_mode(mode_q);
            step       <= '0;
            pos        <= '0;
            chase_up   <= 1'b1;
            duty       <= '0;
            breathe_up <= 1'b1;
            phase      <= 1'b0;
        end else if (tick) begin
            case (mode_q)
                MODE_BINARY: begin
                    step <= step + 1'b1;
                end
                MODE_CHASE: begin
                    if (chase_up) begin
                        if (pos == POS_LAST) begin
                            chase_up <= 1'b0;
                            pos      <= POS_LAST - 1'b1;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            chase_up <= 1'b1;
                            pos      <= POS_W'(1);
                        end else begin
                            pos <= pos - 1'b1;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (breathe_up) begin
                        if (duty > DUTY_TOP) begin
                            duty       <= DUTY_MAX;
                            breathe_up <= 1'b0;
                        end else begin
                            duty <= duty + DUTY_INC;
                        end
                    end else begin
                        if (duty < DUTY_INC) begin
                            duty       <= '0;
                            breathe_up <= 1'b1;
                        end else begin
                            duty <= duty - DUTY_INC;
                        end
                    end
                end
                default: begin
                    phase <= ~phase;
                end
            endcase
        end
    end

    // Pattern decode from the current mode and state.
    // NOTE: led_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        led_next = '0;
        case (mode_q)
            MODE_BINARY:  led_next = step;
            MODE_CHASE:   led_next = LED_ONE << pos;
            MODE_BREATHE: led_next = (pwm_cnt < duty) ? '1 : '0;
            default:      led_next = {N_LEDS{phase}};
        endcase
    end

    // Output register: led follows the state one clk later, glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen. Expected values are queued when the
// stimulus is applied and popped when the DUT output is sampled (negedge).
// A second instance with a slow tick holds each duty value long enough to
// measure the breathe PWM over a full 16-clk period.
module tb_led_pattern_gen;

    localparam int N    = 5;
    localparam int DIV  = 4;
    localparam int DIV2 = 64;
    localparam int PB   = 4;
    localparam int DS   = 4;

    typedef struct {
        string tag;
        int    value;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         mode_next;
    logic [1:0]   mode;
    logic         tick;
    logic [N-1:0] led;

    logic         rst2;
    logic         mode_next2;
    logic [1:0]   mode2;
    logic         tick2;
    logic [N-1:0] led2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    led_pattern_gen #(
        .N_LEDS    (N),
        .TICK_DIV  (DIV),
        .PWM_BITS  (PB),
        .DUTY_STEP (DS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_next (mode_next),
        .mode      (mode),
        .tick      (tick),
        .led       (led)
    );

    led_pattern_gen #(
        .N_LEDS    (N),
        .TICK_DIV  (DIV2),
        .PWM_BITS  (PB),
        .DUTY_STEP (DS)
    ) dut_pwm (
        .clk       (clk),
        .rst       (rst2),
        .mode_next (mode_next2),
        .mode      (mode2),
        .tick      (tick2),
        .led       (led2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_val(input string tag, input int value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check(input int observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d with nothing expected", observed);
            return;
        end
        e = sb.pop_front();
        assert (observed === e.value) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
        end
    endtask

    // Returns at the negedge where tick is high (the next posedge is the tick edge).
    task automatic wait_tick(input bit sel, input string tag);
        int budget = sel ? 2 * DIV2 + 4 : 2 * DIV + 4;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? tick2 : tick) && n < budget);
        if (!(sel ? tick2 : tick)) begin
            checks++;
            errors++;
            $error("FAIL %s: no tick after %0d clks, expected within %0d", tag, n, budget);
        end
    endtask

    // One tick on the main DUT, then led sampled after it has absorbed the new state.
    task automatic tick_check(input string tag, input int exp_led);
        expect_val(tag, exp_led);
        wait_tick(1'b0, tag);
        @(negedge clk);
        @(negedge clk);
        check(int'(led));
    endtask

    task automatic pulse_mode_next();
        mode_next = 1'b1;
        @(negedge clk);
        mode_next = 1'b0;
    endtask

    // Clks from the current negedge until tick is seen high.
    task automatic count_to_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 4 * DIV);
    endtask

    initial begin
        int n;
        int ones;
        int chase_exp[10] = '{2, 4, 8, 16, 8, 4, 2, 1, 2, 4};
        int duty_exp[9]   = '{4, 8, 12, 15, 11, 7, 3, 0, 4};
        int blink_exp[4]  = '{31, 0, 31, 0};

        rst        = 1'b1;
        rst2       = 1'b1;
        mode_next  = 1'b0;
        mode_next2 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        expect_val("reset_led", 0);
        expect_val("reset_mode", 0);
        expect_val("reset_tick", 0);
        check(int'(led));
        check(int'(mode));
        check(int'(tick));
        rst  = 1'b0;
        rst2 = 1'b0;

        // Binary count up to 01101
        for (int i = 1; i <= 13; i++) tick_check($sformatf("binary_%0d", i), i);

        // Async reset between edges clears outputs before the next edge
        #2 rst = 1'b1;
        expect_val("async_rst_led", 0);
        expect_val("async_rst_mode", 0);
        expect_val("async_rst_tick", 0);
        #1;
        check(int'(led));
        check(int'(mode));
        check(int'(tick));
        @(negedge clk);
        rst = 1'b0;
        expect_val("first_tick_after_reset", DIV - 1);
        count_to_tick(n);
        check(n);

        // 33 ticks from reset: wraps through 0 and lands on 00001
        expect_val("binary_wrap_1", 1);
        @(negedge clk);
        @(negedge clk);
        check(int'(led));
        for (int i = 2; i <= 33; i++) tick_check($sformatf("binary_wrap_%0d", i), i % 32);

        // Chase
        pulse_mode_next();
        expect_val("mode_chase", 1);
        check(int'(mode));
        expect_val("chase_start", 1);
        @(negedge clk);
        check(int'(led));
        for (int i = 0; i < 10; i++) tick_check($sformatf("chase_%0d", i), chase_exp[i]);

        // mode_next coincident with tick: mode wins and the prescaler restarts
        wait_tick(1'b0, "coincident_wait");
        pulse_mode_next();
        expect_val("coincident_mode", 2);
        check(int'(mode));
        expect_val("coincident_led_cleared", 0);
        @(negedge clk);
        check(int'(led));
        expect_val("coincident_next_tick", DIV - 2);
        count_to_tick(n);
        check(n);

        // Blink
        @(negedge clk);
        @(negedge clk);
        pulse_mode_next();
        expect_val("mode_blink", 3);
        check(int'(mode));
        expect_val("blink_start", 0);
        @(negedge clk);
        check(int'(led));
        for (int i = 0; i < 4; i++) tick_check($sformatf("blink_%0d", i), blink_exp[i]);

        // Fourth mode_next wraps back to binary
        pulse_mode_next();
        expect_val("mode_wrap", 0);
        check(int'(mode));
        expect_val("wrap_led", 0);
        @(negedge clk);
        check(int'(led));
        tick_check("wrap_binary_first", 1);

        // Breathe on the slow instance; two back-to-back pulses give mode 2
        mode_next2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mode_next2 = 1'b0;
        expect_val("double_pulse_mode", 2);
        check(int'(mode2));
        for (int i = 0; i < 9; i++) begin
            expect_val($sformatf("breathe_on_clks_%0d", i), duty_exp[i]);
            wait_tick(1'b1, "breathe_wait");
            @(negedge clk);
            @(negedge clk);
            ones = 0;
            for (int k = 0; k < 16; k++) begin
                if (led2 == '1) ones++;
                @(negedge clk);
            end
            check(ones);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
